word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter WIDTH_IN_WORD, default 17: bit width of one input word.
REQ-002 SHALL have parameter NUM_WORDS, default 2: words packed per output; legal range 2..16.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 puts the first word in the MSBs (real/imag order), 0 puts it in the LSBs.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port data_i, input, WIDTH_IN_WORD: input word.
REQ-007 SHALL have port valid_i, input, 1: data_i is valid.
REQ-008 SHALL have port first_i, input, 1: qualified by valid_i; marks the word as lane 0.
REQ-009 SHALL have port ready_o, output, 1: the block accepts a word this cycle.
REQ-010 SHALL have port data_o, output, NUM_WORDS*WIDTH_IN_WORD: packed word.
REQ-011 SHALL have port valid_o, output, 1: data_o is valid.
REQ-012 SHALL have port ready_i, input, 1: downstream accepts data_o.
REQ-013 SHALL have port align_err_o, output, 1: one-cycle pulse on a misaligned first_i.

Function
REQ-014 SHALL accept a word when valid_i && ready_o (input transfer) and deliver one when valid_o && ready_i (output transfer).
REQ-015 SHALL keep a lane counter 0..NUM_WORDS-1 that increments on each input transfer and wraps to 0 after lane NUM_WORDS-1.
REQ-016 SHALL store each accepted word into an assembly register at its lane slot: slot k occupies bits [(NUM_WORDS-1-k)*W +: W] when MSB_FIRST=1, and [k*W +: W] when MSB_FIRST=0.
REQ-017 SHALL, on accepting lane NUM_WORDS-1, load the completed word into the output register and assert valid_o on the next cycle; latency from last-word accept to valid_o is 1 cycle.
REQ-018 SHALL hold data_o and valid_o stable while valid_o && !ready_i.
REQ-019 SHALL drive ready_o = !(lane == NUM_WORDS-1 && valid_o && !ready_i); lanes 0..NUM_WORDS-2 are accepted even during an output stall.
REQ-020 SHALL, when an output transfer and a last-lane input transfer occur in the same cycle, load the new word and keep valid_o at 1, giving throughput of one input word per cycle.
REQ-021 SHALL clear valid_o after an output transfer with no new completed word.
REQ-022 SHALL treat first_i on an input transfer with lane == 0 as normal, with no error.
REQ-023 SHALL, on first_i at lane k > 0: discard the k partial words; store the new word as lane 0 and set lane to 1; pulse align_err_o for exactly one cycle on the next cycle; leave the output register untouched.
REQ-024 SHALL ignore first_i when valid_i is 0.
REQ-025 SHALL contain no combinational path from data_i to data_o; ready_o depends on ready_i combinationally only.

Reset
REQ-026 SHALL, on rst_i sampled high, set lane = 0, valid_o = 0, align_err_o = 0, data_o = 0 and the assembly register to 0.
REQ-027 SHALL discard a partially assembled word and any pending output word when reset occurs mid-operation.
REQ-028 SHALL drive ready_o = 1 during and after reset, with no transfer counted while rst_i is high.

Structure
REQ-029 SHALL take LANE_W = $clog2(NUM_WORDS) and a lane-slot offset function from shared package word_packer_pkg.
REQ-030 SHALL place the output register/handshake stage in a single sub-module, word_packer_outreg, parametrised by data width.
REQ-031 SHALL flag NUM_WORDS < 2 at elaboration time.

Verification
REQ-032 SHALL cover: W=17, N=2, MSB_FIRST=1; inputs 17'h00001 then 17'h00002 with ready_i=1 -> data_o=34'h000020002, valid_o high for 1 cycle, 1 cycle after the second accept.
REQ-033 SHALL cover: the same inputs with MSB_FIRST=0 -> data_o=34'h000040001.
REQ-034 SHALL cover: N=4, continuous stream 1..8 with ready_i=1 -> two outputs {1,2,3,4} and {5,6,7,8} on consecutive 4-cycle boundaries, ready_o constantly 1.
REQ-035 SHALL cover: N=2, ready_i=0 after the first output; feed 3,4 -> ready_o drops while the last lane is pending, data_o holds {1,2}; raise ready_i -> {3,4} delivered with no word lost.
REQ-036 SHALL cover: N=4; feed A,B with first_i on A, then C with first_i=1 -> align_err_o pulses once, and the next output is {C,D,E,F}.
REQ-037 SHALL cover: rst_i asserted after 1 of 2 words -> valid_o=0 and data_o=0; the next two words form a correct output with no residue.

Source files
------------

// File: rtl/word_packer_pkg.sv
// word_packer_pkg: shared lane sizing and lane-slot placement helpers for word_packer
package word_packer_pkg;
    localparam int MAX_WORDS = 16;
    function automatic int lane_bits(input int n);
        return $clog2(n);
    endfunction
    // Bit offset of lane k inside an n-word packed vector of w-bit words
    function automatic int slot_offset(input int k, input int n, input int w, input bit msb_first);
        return msb_first ? (n - 1 - k) * w : k * w;
    endfunction
endpackage

// File: rtl/word_packer_outreg.sv
// word_packer_outreg: output holding register with valid/ready handshake
// ports: clk_i/rst_i clock and sync reset, load/word completed word in,
//        ready_i downstream accept, data_o/valid_o registered output
module word_packer_outreg #(
    parameter int DW = 34
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load,
    input  logic [DW-1:0] word,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (load) data_o <= word;
            valid_o <= load || (valid_o && !ready_i);
        end
    end
endmodule

// File: rtl/word_packer.sv
// word_packer: packs NUM_WORDS input words into one wide output word
// ports: clk_i/rst_i clock and sync reset, data_i/valid_i/first_i/ready_o input side,
//        data_o/valid_o/ready_i output side, align_err_o pulse on misaligned first_i
module word_packer
    import word_packer_pkg::*;
#(
    parameter int WIDTH_IN_WORD = 17,
    parameter int NUM_WORDS     = 2,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [WIDTH_IN_WORD-1:0]           data_i,
    input  logic                               valid_i,
    input  logic                               first_i,
    output logic                               ready_o,
    output logic [NUM_WORDS*WIDTH_IN_WORD-1:0] data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               align_err_o
);
    localparam int DW = NUM_WORDS * WIDTH_IN_WORD;
    localparam int LANE_W = lane_bits(NUM_WORDS);
    localparam logic [LANE_W-1:0] LAST = LANE_W'(NUM_WORDS - 1);
    if (NUM_WORDS < 2 || NUM_WORDS > MAX_WORDS) begin : g_bad_num_words
        $error("word_packer: NUM_WORDS must be in 2..16");
    end
    logic [LANE_W-1:0] lane, eff_lane;
    logic [DW-1:0] asm_q, asm_next, word_ext, word_mask;
    logic xfer, misalign, load;
    int off;
    // Only the last lane can be blocked, and only while the output slot is still occupied
    assign ready_o = rst_i || !(lane == LAST && valid_o && !ready_i);
    always_comb begin
        xfer      = valid_i && ready_o;
        misalign  = xfer && first_i && lane != '0;
        eff_lane  = misalign ? '0 : lane;
        off       = slot_offset(int'(eff_lane), NUM_WORDS, WIDTH_IN_WORD, MSB_FIRST);
        word_ext  = DW'(data_i) << off;
        word_mask = DW'({WIDTH_IN_WORD{1'b1}}) << off;
        // A misaligned first word drops the partial assembly before taking lane 0
        asm_next  = ((misalign ? '0 : asm_q) & ~word_mask) | word_ext;
        load      = xfer && eff_lane == LAST;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane        <= '0;
            asm_q       <= '0;
            align_err_o <= 1'b0;
        end else begin
            align_err_o <= misalign;
            if (xfer) begin
                lane  <= load ? '0 : eff_lane + 1'b1;
                asm_q <= asm_next;
            end
        end
    end
    word_packer_outreg #(.DW(DW)) u_outreg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (load),
        .word   (asm_next),
        .ready_i(ready_i),
        .data_o (data_o),
        .valid_o(valid_o)
    );
endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed self-checking bench for word_packer (N=2 both orders, N=4)
module tb_word_packer;
    logic clk = 1'b0;
    logic rst;
    logic [16:0] d2, d4;
    logic v2, f2, r2, v4, f4, r4;
    logic rdy_a, vo_a, err_a, rdy_b, vo_b, err_b, rdy_c, vo_c, err_c;
    logic [33:0] do_a, do_b;
    logic [67:0] do_c;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    word_packer #(.WIDTH_IN_WORD(17), .NUM_WORDS(2), .MSB_FIRST(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .data_i(d2), .valid_i(v2), .first_i(f2), .ready_o(rdy_a),
        .data_o(do_a), .valid_o(vo_a), .ready_i(r2), .align_err_o(err_a));
    word_packer #(.WIDTH_IN_WORD(17), .NUM_WORDS(2), .MSB_FIRST(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .data_i(d2), .valid_i(v2), .first_i(f2), .ready_o(rdy_b),
        .data_o(do_b), .valid_o(vo_b), .ready_i(r2), .align_err_o(err_b));
    word_packer #(.WIDTH_IN_WORD(17), .NUM_WORDS(4), .MSB_FIRST(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .data_i(d4), .valid_i(v4), .first_i(f4), .ready_o(rdy_c),
        .data_o(do_c), .valid_o(vo_c), .ready_i(r4), .align_err_o(err_c));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [67:0] p4(input logic [16:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    initial begin
        rst = 1'b1;
        d2 = '0; v2 = 1'b0; f2 = 1'b0; r2 = 1'b1;
        d4 = '0; v4 = 1'b0; f4 = 1'b0; r4 = 1'b1;
        tick();
        tick();
        chk("rst_valid_a", vo_a, 1'b0);
        chk("rst_data_a", do_a, 34'h0);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_ready_a", rdy_a, 1'b1);
        chk("rst_valid_c", vo_c, 1'b0);
        chk("rst_ready_c", rdy_c, 1'b1);
        rst = 1'b0;

        // two-word pack, both lane orders
        v2 = 1'b1; d2 = 17'h00001; f2 = 1'b1;
        tick();
        chk("p2_no_early_valid", vo_a, 1'b0);
        d2 = 17'h00002; f2 = 1'b0;
        tick();
        v2 = 1'b0;
        chk("p2_valid", vo_a, 1'b1);
        chk("p2_msb_data", do_a, 34'h000020002);
        chk("p2_lsb_data", do_b, 34'h000040001);
        chk("p2_lsb_valid", vo_b, 1'b1);
        tick();
        chk("p2_valid_one_cycle", vo_a, 1'b0);

        // output stall with last lane pending
        r2 = 1'b0;
        v2 = 1'b1; d2 = 17'h00001;
        tick();
        d2 = 17'h00002;
        tick();
        chk("stall_first_out", do_a, 34'h000020002);
        d2 = 17'h00003;
        #1;
        chk("stall_lane0_ready", rdy_a, 1'b1);
        tick();
        d2 = 17'h00004;
        #1;
        chk("stall_ready_low", rdy_a, 1'b0);
        tick();
        chk("stall_valid_hold", vo_a, 1'b1);
        chk("stall_data_hold", do_a, 34'h000020002);
        chk("stall_ready_still_low", rdy_a, 1'b0);
        r2 = 1'b1;
        #1;
        chk("stall_ready_back", rdy_a, 1'b1);
        tick();
        v2 = 1'b0;
        chk("stall_b2b_valid", vo_a, 1'b1);
        chk("stall_b2b_data", do_a, 34'h000060004);
        chk("stall_b2b_data_lsb", do_b, 34'h000080003);
        tick();
        chk("stall_drained", vo_a, 1'b0);

        // four-word continuous stream
        v4 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            d4 = 17'(i);
            f4 = (i == 1);
            #1;
            chk($sformatf("s4_ready_%0d", i), rdy_c, 1'b1);
            tick();
            if (i == 4) begin
                chk("s4_valid_1", vo_c, 1'b1);
                chk("s4_data_1", do_c, p4(17'd1, 17'd2, 17'd3, 17'd4));
            end
            if (i == 5) chk("s4_valid_gap", vo_c, 1'b0);
            if (i == 8) begin
                chk("s4_valid_2", vo_c, 1'b1);
                chk("s4_data_2", do_c, p4(17'd5, 17'd6, 17'd7, 17'd8));
            end
        end
        v4 = 1'b0; f4 = 1'b0;
        tick();
        chk("s4_drained", vo_c, 1'b0);

        // misaligned first_i
        v4 = 1'b1; d4 = 17'h1AAAA; f4 = 1'b1;
        tick();
        d4 = 17'h0BBBB; f4 = 1'b0;
        tick();
        chk("al_no_err_yet", err_c, 1'b0);
        d4 = 17'h0CCCC; f4 = 1'b1;
        tick();
        chk("al_err_pulse", err_c, 1'b1);
        chk("al_no_valid", vo_c, 1'b0);
        d4 = 17'h0DDDD; f4 = 1'b0;
        tick();
        chk("al_err_cleared", err_c, 1'b0);
        d4 = 17'h0EEEE;
        tick();
        chk("al_not_complete", vo_c, 1'b0);
        d4 = 17'h0FFFF;
        tick();
        v4 = 1'b0;
        chk("al_valid", vo_c, 1'b1);
        chk("al_data", do_c, p4(17'h0CCCC, 17'h0DDDD, 17'h0EEEE, 17'h0FFFF));
        chk("al_err_once", err_c, 1'b0);
        tick();

        // reset mid-operation with pending output and partial word
        r2 = 1'b0;
        v2 = 1'b1; d2 = 17'h00001;
        tick();
        d2 = 17'h00002;
        tick();
        d2 = 17'h00005;
        tick();
        #1;
        chk("mr_ready_low_pre", rdy_a, 1'b0);
        rst = 1'b1; d2 = 17'h00009;
        #1;
        chk("mr_ready_in_rst", rdy_a, 1'b1);
        tick();
        chk("mr_valid", vo_a, 1'b0);
        chk("mr_data", do_a, 34'h0);
        tick();
        rst = 1'b0; r2 = 1'b1; d2 = 17'h00007;
        #1;
        chk("mr_ready_after", rdy_a, 1'b1);
        tick();
        chk("mr_no_residue", vo_a, 1'b0);
        d2 = 17'h00008;
        tick();
        v2 = 1'b0;
        chk("mr_valid_new", vo_a, 1'b1);
        chk("mr_data_new", do_a, 34'h0000E0008);
        chk("mr_data_new_lsb", do_b, 34'h000100007);
        tick();
        chk("mr_drained", vo_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
